// File: rtl/ahb_sram_slave.sv
// AHB-Lite scratch-RAM slave: all burst types, byte lanes, configurable wait states,
// SEQ-address/beat checking with a two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic                  hselx,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hreadyin,
  output logic                  hready,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int unsigned Bytes    = DATA_WIDTH / 8;
  localparam int unsigned ByteBits = $clog2(Bytes);
  localparam int unsigned IdxBits  = $clog2(MEM_DEPTH);
  localparam int unsigned LowBits  = ByteBits + IdxBits;

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e                state_q, state_d;
  logic [2:0]            wait_q, wait_d;
  logic [LowBits-1:0]    addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] exp_q, exp_d;
  logic [3:0]            beats_q, beats_d;
  logic                  incr_q, incr_d;
  logic [DATA_WIDTH-1:0] hrdata_q;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  accept, is_seq, is_wrap, err;
  logic [3:0]            burst_len_m1;
  logic [ADDR_WIDTH-1:0] size_bytes, wrap_mask, next_addr;
  logic [Bytes-1:0]      lanes, lane_en;
  logic [IdxBits-1:0]    idx;

  assign idx    = addr_q[LowBits-1:ByteBits];
  assign is_seq = (htrans == 2'b11);
  assign accept = hselx && hreadyin && htrans[1] &&
                  (state_q inside {StIdle, StData, StErr2});

  always_comb begin
    unique case (hburst[2:1])
      2'b01:   burst_len_m1 = 4'd3;
      2'b10:   burst_len_m1 = 4'd7;
      2'b11:   burst_len_m1 = 4'd15;
      default: burst_len_m1 = 4'd0;
    endcase
  end

  // Wrapping bursts keep the bits above the n * 2^hsize boundary fixed.
  assign is_wrap    = !hburst[0] && (hburst[2:1] != 2'b00);
  assign size_bytes = ADDR_WIDTH'(1) << hsize;
  assign wrap_mask  = ((ADDR_WIDTH'(burst_len_m1) + ADDR_WIDTH'(1)) << hsize) - ADDR_WIDTH'(1);
  assign next_addr  = is_wrap ? ((haddr & ~wrap_mask) | ((haddr + size_bytes) & wrap_mask))
                              : (haddr + size_bytes);

  assign err = (hsize > 3'(ByteBits)) ||
               ((haddr & (size_bytes - ADDR_WIDTH'(1))) != '0) ||
               ((haddr >> ByteBits) >= ADDR_WIDTH'(MEM_DEPTH)) ||
               (is_seq && ((haddr != exp_q) || (!incr_q && (beats_q == 4'd0))));

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    exp_d   = exp_q;
    beats_d = beats_q;
    incr_d  = incr_q;
    unique case (state_q)
      StWait: begin
        if (wait_q <= 3'd1) state_d = StData;
        else                wait_d  = wait_q - 3'd1;
      end
      StErr1: state_d = StErr2;
      default: begin
        state_d = StIdle;
        if (accept) begin
          addr_d  = haddr[LowBits-1:0];
          write_d = hwrite;
          size_d  = hsize;
          if (err) begin
            state_d = StErr1;
            // A failed NONSEQ leaves no burst for later SEQ beats to continue.
            if (!is_seq) begin
              beats_d = 4'd0;
              incr_d  = 1'b0;
            end
          end else begin
            state_d = (WAIT_STATES > 0) ? StWait : StData;
            wait_d  = 3'(WAIT_STATES);
            exp_d   = next_addr;
            if (is_seq) begin
              if (!incr_q) beats_d = beats_q - 4'd1;
            end else begin
              beats_d = burst_len_m1;
              incr_d  = (hburst == 3'b001);
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    lanes = '0;
    for (int unsigned i = 0; i < Bytes; i++) begin
      lanes[i] = (i >= 32'(addr_q[ByteBits-1:0])) &&
                 (i < 32'(addr_q[ByteBits-1:0]) + (32'd1 << size_q));
    end
  end

  always_comb begin
    hready  = 1'b1;
    hresp   = 2'b00;
    hrdata  = hrdata_q;
    lane_en = '0;
    unique case (state_q)
      StWait: hready = 1'b0;
      StErr1: begin
        hready = 1'b0;
        hresp  = 2'b01;
      end
      StErr2: hresp = 2'b01;
      StData: begin
        if (write_q) lane_en = lanes;
        else         hrdata  = mem_q[idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge hclk) begin
    for (int unsigned i = 0; i < Bytes; i++) begin
      if (lane_en[i]) mem_q[idx][8*i +: 8] <= hwdata[8*i +: 8];
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q  <= StIdle;
      wait_q   <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      exp_q    <= '0;
      beats_q  <= '0;
      incr_q   <= 1'b0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      exp_q    <= exp_d;
      beats_q  <= beats_d;
      incr_q   <= incr_d;
      hrdata_q <= hrdata;
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 2 wait states) behind a tiny decoder,
// a pipelined burst master, and a byte-array memory model.
module tb_ahb_sram_slave;

  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int NBYTES = 256 * 4;

  logic          hclk = 1'b0;
  logic          hreset_n;
  logic          hselx, hwrite;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic [2:0]    hsize, hburst;
  logic [DW-1:0] hwdata;
  logic          hready0, hready2, hready_m;
  logic [1:0]    hresp0, hresp2, hresp_m;
  logic [DW-1:0] hrdata0, hrdata2, hrdata_m;
  int            sel;

  int checks   = 0;
  int failures = 0;

  assign hready_m = (sel == 1) ? hready2 : hready0;
  assign hresp_m  = (sel == 1) ? hresp2  : hresp0;
  assign hrdata_m = (sel == 1) ? hrdata2 : hrdata0;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset_n(hreset_n), .hselx(hselx && (sel == 0)), .haddr(haddr),
    .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hreadyin(hready_m), .hready(hready0), .hresp(hresp0), .hrdata(hrdata0)
  );

  ahb_sram_slave #(.WAIT_STATES(2)) u_dut2 (
    .hclk(hclk), .hreset_n(hreset_n), .hselx(hselx && (sel == 1)), .haddr(haddr),
    .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hreadyin(hready_m), .hready(hready2), .hresp(hresp2), .hrdata(hrdata2)
  );

  logic [7:0]  mem_m [2][NBYTES];

  int          n_beats;
  logic [2:0]  b_size, b_burst;
  logic [31:0] b_addr [16];
  logic [1:0]  b_trans [16];
  logic [31:0] b_wdata [16];
  logic        b_wr [16];
  bit          b_experr [16];
  logic [31:0] r_data [16];
  logic [1:0]  r_resp [16];
  logic [1:0]  r_resp_low [16];
  int          r_waits [16];
  int          r_cycles;
  bit          r_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int d, input int a);
    int w;
    w = (a / 4) * 4;
    return {mem_m[d][w+3], mem_m[d][w+2], mem_m[d][w+1], mem_m[d][w]};
  endfunction

  task automatic model_write(input int d, input int a, input logic [2:0] sz,
                             input logic [31:0] data);
    for (int j = 0; j < (1 << sz); j++) mem_m[d][a+j] = data[8*((a+j)%4) +: 8];
  endtask

  function automatic int beats_of(input logic [2:0] bu, input int len);
    if (bu == 3'b000) return 1;
    if (bu == 3'b001) return len;
    return 2 << (bu >> 1);
  endfunction

  task automatic plan_burst(input logic wr, input logic [2:0] bu, input logic [2:0] sz,
                            input int start, input int len);
    int n, step, span, base;
    n    = beats_of(bu, len);
    step = 1 << sz;
    span = n * step;
    base = start - (start % span);
    n_beats = n;
    b_size  = sz;
    b_burst = bu;
    for (int k = 0; k < 16; k++) begin
      if (bu >= 3'b010 && !bu[0]) b_addr[k] = 32'(base + ((start - base + k * step) % span));
      else                        b_addr[k] = 32'(start + k * step);
      b_trans[k]  = (k == 0) ? 2'b10 : 2'b11;
      b_wdata[k]  = $urandom;
      b_wr[k]     = wr;
      b_experr[k] = 1'b0;
    end
  endtask

  task automatic drive_idle();
    hselx  = 1'b0;
    htrans = 2'b00;
    haddr  = '0;
    hwrite = 1'b0;
  endtask

  task automatic drive_addr(input int k);
    hselx  = 1'b1;
    haddr  = b_addr[k];
    hwrite = b_wr[k];
    htrans = b_trans[k];
    hsize  = b_size;
    hburst = b_burst;
  endtask

  // Pipelined master: the next address phase overlaps the current data phase.
  task automatic run_burst();
    int ai, di, cnt;
    bit started, rdy;
    ai = 0; di = -1; cnt = 0; started = 0; r_done = 0; r_cycles = 0;
    for (int k = 0; k < 16; k++) begin
      r_waits[k] = 0; r_resp[k] = 2'b11; r_resp_low[k] = 2'b00; r_data[k] = '0;
    end
    @(posedge hclk); #1;
    drive_addr(0);
    for (int c = 0; c < 500 && !r_done; c++) begin
      @(negedge hclk);
      rdy = hready_m;
      if (di >= 0) begin
        if (!rdy) begin
          r_waits[di]++;
          r_resp_low[di] = hresp_m;
        end else begin
          r_data[di] = hrdata_m;
          r_resp[di] = hresp_m;
          r_cycles   = cnt + 1;
        end
      end
      @(posedge hclk); #1;
      if (rdy && !started) begin
        started = 1; cnt = 0;
      end else if (started) cnt++;
      if (rdy) begin
        if (ai < n_beats) begin
          di = ai; ai++;
        end else di = -1;
        if (di < 0) begin
          drive_idle();
          r_done = 1;
        end else begin
          hwdata = b_wdata[di];
          if (ai < n_beats) drive_addr(ai);
          else              drive_idle();
        end
      end
    end
    if (!r_done) drive_idle();
    chk("burst_completes", r_done, 1);
  endtask

  task automatic finish_burst(input string tag);
    for (int k = 0; k < n_beats; k++) begin
      if (b_experr[k]) begin
        chk({tag, "_err_resp"}, r_resp[k], 2'b01);
        chk({tag, "_err_first"}, r_resp_low[k], 2'b01);
        chk({tag, "_err_len"}, r_waits[k], 1);
      end else begin
        chk({tag, "_resp"}, r_resp[k], 2'b00);
        chk({tag, "_waits"}, r_waits[k], (sel == 1) ? 2 : 0);
        if (b_wr[k]) model_write(sel, int'(b_addr[k]), b_size, b_wdata[k]);
        else         chk({tag, "_rdata"}, r_data[k], model_word(sel, int'(b_addr[k])));
      end
    end
  endtask

  task automatic read_word(input int a, input string tag);
    plan_burst(1'b0, 3'b000, 3'd2, a, 1);
    run_burst();
    finish_burst(tag);
  endtask

  task automatic single_err(input int a, input logic [2:0] sz, input string tag);
    plan_burst(1'b1, 3'b000, 3'd2, 0, 1);
    b_size      = sz;
    b_addr[0]   = 32'(a);
    b_experr[0] = 1'b1;
    run_burst();
    finish_burst(tag);
  endtask

  initial begin
    logic [2:0] bu, sz;
    logic       wr;
    int         n, len, span, st;

    sel      = 0;
    hreset_n = 1'b0;
    hwdata   = '0;
    hsize    = 3'd2;
    hburst   = 3'b000;
    drive_idle();
    #1;
    chk("reset_hready0", hready0, 1);
    chk("reset_hresp0", hresp0, 2'b00);
    chk("reset_hrdata0", hrdata0, '0);
    chk("reset_hready2", hready2, 1);
    chk("reset_hresp2", hresp2, 2'b00);
    chk("reset_hrdata2", hrdata2, '0);
    @(posedge hclk); @(posedge hclk); #1;
    hreset_n = 1'b1;

    // Every word of both memories holds its own index.
    for (int d = 0; d < 2; d++) begin
      sel = d;
      for (int blk = 0; blk < 16; blk++) begin
        plan_burst(1'b1, 3'b111, 3'd2, blk * 64, 16);
        for (int k = 0; k < 16; k++) b_wdata[k] = 32'(blk * 16 + k);
        run_burst();
        finish_burst("preload");
      end
    end

    sel = 0;
    plan_burst(1'b1, 3'b000, 3'd2, 'h10, 1);
    b_wdata[0] = 32'hDEADBEEF;
    run_burst();
    finish_burst("single_wr");
    read_word('h10, "single_rd");
    chk("single_rd_value", r_data[0], 32'hDEADBEEF);
    @(negedge hclk);
    chk("hrdata_hold_idle", hrdata_m, 32'hDEADBEEF);

    plan_burst(1'b1, 3'b000, 3'd0, 'h13, 1);
    b_wdata[0] = 32'hAA000000;
    run_burst();
    finish_burst("byte_wr");
    @(negedge hclk);
    chk("hrdata_hold_write", hrdata_m, 32'hDEADBEEF);
    read_word('h10, "byte_rd");
    chk("byte_rd_value", r_data[0], 32'hAAADBEEF);

    plan_burst(1'b0, 3'b010, 3'd2, 'h38, 4);
    run_burst();
    finish_burst("wrap4");
    chk("wrap4_b0", r_data[0], 32'h0E);
    chk("wrap4_b1", r_data[1], 32'h0F);
    chk("wrap4_b2", r_data[2], 32'h0C);
    chk("wrap4_b3", r_data[3], 32'h0D);

    sel = 1;
    plan_burst(1'b0, 3'b101, 3'd2, 'h80, 8);
    run_burst();
    finish_burst("incr8_ws2");
    chk("incr8_ws2_cycles", r_cycles, 24);

    sel = 0;
    plan_burst(1'b1, 3'b001, 3'd2, 'h3C, 2);
    b_addr[1]   = 32'h44;
    b_experr[1] = 1'b1;
    run_burst();
    finish_burst("seq_addr_err");
    read_word('h44, "seq_addr_err_mem");

    single_err('h402, 3'd2, "misalign_oob");
    single_err('h12, 3'd2, "misalign");
    read_word('h10, "misalign_mem");
    single_err('h400, 3'd2, "out_of_range");
    read_word('h0, "out_of_range_mem");
    single_err('h20, 3'd3, "size_err");
    read_word('h20, "size_err_mem");

    plan_burst(1'b1, 3'b011, 3'd2, 'h100, 4);
    n_beats     = 5;
    b_addr[4]   = 32'h110;
    b_experr[4] = 1'b1;
    run_burst();
    finish_burst("incr4_overrun");
    read_word('h110, "incr4_overrun_mem");

    plan_burst(1'b0, 3'b011, 3'd2, 'h200, 4);
    b_trans[2] = 2'b10;
    b_addr[2]  = 32'h300;
    b_addr[3]  = 32'h304;
    run_burst();
    finish_burst("nonseq_restart");

    plan_burst(1'b1, 3'b000, 3'd2, 'h60, 1);
    n_beats    = 2;
    b_addr[1]  = 32'h60;
    b_trans[1] = 2'b10;
    b_wr[1]    = 1'b0;
    run_burst();
    finish_burst("raw");

    for (int it = 0; it < 40; it++) begin
      sel  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      wr   = 1'($urandom_range(0, 1));
      bu   = 3'($urandom_range(0, 7));
      sz   = 3'($urandom_range(0, 2));
      len  = $urandom_range(1, 8);
      n    = beats_of(bu, len);
      span = n << sz;
      st   = $urandom_range(0, NBYTES - span);
      st   = st & ~((1 << sz) - 1);
      plan_burst(wr, bu, sz, st, len);
      run_burst();
      finish_burst("rand");
      if (wr) begin
        for (int k = 0; k < 16; k++) b_wr[k] = 1'b0;
        run_burst();
        finish_burst("rand_rb");
      end
    end

    sel = 1;
    @(posedge hclk); #1;
    hselx  = 1'b1;
    haddr  = 32'h90;
    hwrite = 1'b1;
    htrans = 2'b10;
    hsize  = 3'd2;
    hburst = 3'b000;
    @(posedge hclk); #1;
    drive_idle();
    hwdata = 32'hCAFEF00D;
    @(negedge hclk);
    chk("rst_in_wait", hready_m, 0);
    hreset_n = 1'b0;
    #1;
    chk("rst_hready", hready_m, 1);
    chk("rst_hresp", hresp_m, 2'b00);
    chk("rst_hrdata", hrdata_m, '0);
    @(posedge hclk); @(posedge hclk); #1;
    hreset_n = 1'b1;
    read_word('h90, "rst_write_dropped");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- Parametrised AHB-Lite memory slave; successor to the fixed 32-bit single/incr4/wrap4 slave.
- Supports every burst type (SINGLE, INCR, INCR4/8/16, WRAP4/8/16) and every transfer size up to the bus width.
- Adds configurable wait states, byte-lane writes, and SEQ-address checking with a proper two-cycle ERROR response.
- Sits on the AHB matrix as a scratch-RAM target behind the address decoder.

Parameters:
- DATA_WIDTH, 32, bus width in bits; legal values 32 or 64.
- ADDR_WIDTH, 32, haddr width.
- MEM_DEPTH, 256, memory depth in DATA_WIDTH words; power of 2.
- WAIT_STATES, 0, hready-low cycles inserted per OKAY data phase; range 0..7.

Ports:
- hclk  in  1  clock.
- hreset_n  in  1  reset; asynchronous, active-low.
- hselx  in  1  slave select from decoder.
- haddr  in  ADDR_WIDTH  byte address.
- hwrite  in  1  1 = write.
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hsize  in  3  log2 of transfer bytes.
- hburst  in  3  SINGLE=000, INCR=001, WRAP4=010, INCR4=011, WRAP8=100, INCR8=101, WRAP16=110, INCR16=111.
- hwdata  in  DATA_WIDTH  write data, valid in data phase.
- hreadyin  in  1  bus-level hready; previous transfer complete.
- hready  out  1  data phase complete.
- hresp  out  2  00 = OKAY, 01 = ERROR.
- hrdata  out  DATA_WIDTH  read data.

Behaviour:
- Reset values: hready=1, hresp=00, hrdata=0, FSM in IDLE_ST, beat counter=0, expected address=0. Memory array is not reset.
- Address phase accepted when hselx && hreadyin && htrans[1]==1. The slave registers hwrite, haddr, hsize and hburst. The data phase starts the next cycle.
- Unselected transfers, or IDLE/BUSY htrans: no data phase; hready=1, hresp=00, no memory access.
- Error conditions, checked at accept:
  - hsize > log2(DATA_WIDTH/8);
  - haddr not aligned to 2^hsize;
  - word index (haddr / (DATA_WIDTH/8)) >= MEM_DEPTH;
  - SEQ with haddr != expected next address.
- FSM states: IDLE_ST, WAIT_ST, DATA_ST, ERR1_ST, ERR2_ST.
  - IDLE_ST: on accept, go to ERR1_ST if an error condition holds; else WAIT_ST if WAIT_STATES>0; else DATA_ST.
  - WAIT_ST: hready=0, hresp=00. Down-counter loads WAIT_STATES; go to DATA_ST when the count reaches 1.
  - DATA_ST: hready=1, hresp=00. Write: byte lanes selected by hsize and haddr low bits are written from the same lanes of hwdata at the end of the cycle. Read: hrdata = full memory word at the registered index, read combinationally. If a new address phase is accepted in the same cycle, branch as from IDLE_ST; otherwise return to IDLE_ST.
  - ERR1_ST: hready=0, hresp=01; go to ERR2_ST.
  - ERR2_ST: hready=1, hresp=01; no memory update; accepts a new address phase like DATA_ST.
- Expected-address update on each accepted OKAY beat: next = addr + 2^hsize.
  - For WRAPn: wrap within a boundary of n * 2^hsize bytes; upper address bits are held.
  - INCR/INCRn: linear increment.
- Beat counter:
  - NONSEQ loads remaining beats (n-1 for fixed-length bursts, unbounded for INCR).
  - A SEQ beyond the burst length is an error.
  - NONSEQ always restarts checking, even mid-burst; this covers an early burst termination.
- Read-after-write to the same word in back-to-back transfers returns the newly written data. The write commits at the end of DATA_ST, before the next read's data phase.
- hrdata holds its last value outside read data phases.
- Reset asserted mid-transfer: immediate return to the reset values; the in-flight write is dropped.

Test Plan:
- SINGLE word write 0xDEADBEEF to 0x10, then SINGLE read of 0x10 with WAIT_STATES=0 -> hready stays 1; hrdata=0xDEADBEEF in the read data phase; hresp=00.
- Byte write 0xAA to 0x13 with hwdata=0xAA000000, then word read of 0x10 -> hrdata=0xAAADBEEF.
- WRAP4 word read starting at 0x38 (SEQ addresses 0x3C, 0x30, 0x34), memory preloaded with index values -> hrdata 0x0E, 0x0F, 0x0C, 0x0D; all OKAY.
- INCR8 with WAIT_STATES=2 -> each beat shows hready low for exactly 2 cycles then high; 8 beats complete in 24 cycles after the first address phase.
- Error cases, each giving a two-cycle ERROR (hready 0 then 1, hresp=01) with memory unchanged:
  - SEQ beat at 0x44 when 0x40 is expected;
  - a word access to 0x402 (misaligned);
  - an access at word index 256 (0x400).
- Assert hreset_n low during WAIT_ST of a write -> hready=1, hresp=00 the same cycle; the target word keeps its old value.
